// File: rtl/counter_pkg.sv
// Shared encodings and sizing helpers for the counter and timing blocks.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int ctr_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Enable prescaler: emits a combinational step pulse on every PRESCALE-th qualified enable.
module tick_divider
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic stepPulse
);

  generate
    if (PRESCALE == 1) begin : g_direct
      logic unused_ctl;
      assign unused_ctl = clock | reset | clear;
      assign stepPulse  = enable;
    end else begin : g_div
      localparam int PW = ctr_width(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase;

      // Phase only advances on enable, so a paused count keeps its partial progress.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          phase <= '0;
        end else if (clear) begin
          phase <= '0;
        end else if (enable) begin
          if (phase == LAST) phase <= '0;
          else               phase <= phase + PW'(1);
        end
      end

      assign stepPulse = enable && (phase == LAST);
    end
  endgenerate

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with clear/load, wrap or saturate mode, prescaled enable and step flags.
module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MODULUS  = 4,
  parameter int PRESCALE = 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrapped,
  output logic             terminal
);

  // One guard bit so MODULUS == 2**WIDTH never depends on natural overflow.
  localparam int XW = WIDTH + 1;
  localparam logic [XW-1:0] TOP = XW'(MODULUS - 1);

  logic             step;
  logic             div_clear;
  logic [XW-1:0]    count_x;
  logic [WIDTH-1:0] step_value;
  logic             step_wraps;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [XW-1:0] vx;
    vx = {1'b0, v};
    return (vx > TOP) ? WIDTH'(TOP) : v;
  endfunction

  function automatic logic [XW-1:0] next_step(input logic [XW-1:0] cx, input logic dir_up);
    if (dir_up) begin
      if (cx == TOP) return (SATURATE == MODE_SAT) ? cx : '0;
      return cx + XW'(1);
    end
    if (cx == '0) return (SATURATE == MODE_SAT) ? cx : TOP;
    return cx - XW'(1);
  endfunction

  assign count_x    = {1'b0, count};
  assign div_clear  = clear | load;
  assign step_value = WIDTH'(next_step(count_x, up));
  assign step_wraps = (SATURATE == MODE_WRAP) && (up ? (count_x == TOP) : (count_x == '0));
  assign terminal   = up ? (count_x == TOP) : (count_x == '0);

  tick_divider #(
    .PRESCALE (PRESCALE)
  ) u_div (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .clear     (div_clear),
    .stepPulse (step)
  );

  // Priority: clear, then load, then step; a load swallows a coincident step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count   <= '0;
      tick    <= 1'b0;
      wrapped <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      tick    <= 1'b0;
      wrapped <= 1'b0;
    end else if (load) begin
      count   <= clamp_load(loadValue);
      tick    <= 1'b0;
      wrapped <= 1'b0;
    end else if (step) begin
      count   <= step_value;
      tick    <= 1'b1;
      wrapped <= step_wraps;
    end else begin
      tick    <= 1'b0;
      wrapped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: four parameterisations share stimulus, checked against a behavioural scoreboard.
module tb_mod_counter;

  logic       clock = 1'b0;
  logic       reset, enable, up, clear, load;
  logic [3:0] lv;

  logic [1:0] cA;  logic tA, wA, mA;
  logic [3:0] cB;  logic tB, wB, mB;
  logic [3:0] cC;  logic tC, wC, mC;
  logic [2:0] cD;  logic tD, wD, mD;

  always #5 clock = ~clock;

  // A: defaults; B: decade wrap; C: decade saturate, prescale 4; D: octal wrap, prescale 3
  mod_counter #(.WIDTH(2), .MODULUS(4),  .PRESCALE(1), .SATURATE(0)) dutA (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .loadValue(lv[1:0]), .count(cA), .tick(tA), .wrapped(wA), .terminal(mA));
  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) dutB (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .loadValue(lv), .count(cB), .tick(tB), .wrapped(wB), .terminal(mB));
  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .SATURATE(1)) dutC (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .loadValue(lv), .count(cC), .tick(tC), .wrapped(wC), .terminal(mC));
  mod_counter #(.WIDTH(3), .MODULUS(8),  .PRESCALE(3), .SATURATE(0)) dutD (
    .clock(clock), .reset(reset), .enable(enable), .up(up), .clear(clear), .load(load),
    .loadValue(lv[2:0]), .count(cD), .tick(tD), .wrapped(wD), .terminal(mD));

  int pw[4] = '{2, 4, 4, 3};
  int pm[4] = '{4, 10, 10, 8};
  int pp[4] = '{1, 1, 4, 3};
  int ps[4] = '{0, 0, 1, 0};

  int mc[4];
  int mph[4];

  typedef struct {
    int inst;
    int cnt;
    bit tk;
    bit wr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit en, u, c, l;
    int lv;
    int ec;
    bit et, ew;
  } vec_t;
  vec_t tbl[13];

  int errors = 0;
  int checks = 0;

  function automatic int act_cnt(input int i);
    case (i)
      0: return int'(cA);
      1: return int'(cB);
      2: return int'(cC);
      default: return int'(cD);
    endcase
  endfunction

  function automatic int act_tk(input int i);
    case (i)
      0: return int'(tA);
      1: return int'(tB);
      2: return int'(tC);
      default: return int'(tD);
    endcase
  endfunction

  function automatic int act_wr(input int i);
    case (i)
      0: return int'(wA);
      1: return int'(wB);
      2: return int'(wC);
      default: return int'(wD);
    endcase
  endfunction

  function automatic int act_term(input int i);
    case (i)
      0: return int'(mA);
      1: return int'(mB);
      2: return int'(mC);
      default: return int'(mD);
    endcase
  endfunction

  function automatic int model_term(input int i, input bit u);
    return u ? int'(mc[i] == pm[i] - 1) : int'(mc[i] == 0);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i, input bit en, input bit u, input bit c,
                            input bit l, input int lvv);
    exp_t e;
    int   lvm;
    lvm = lvv & ((1 << pw[i]) - 1);
    e.inst = i;
    e.tk = 1'b0;
    e.wr = 1'b0;
    if (c) begin
      mc[i] = 0;
      mph[i] = 0;
    end else if (l) begin
      mc[i] = (lvm >= pm[i]) ? pm[i] - 1 : lvm;
      mph[i] = 0;
    end else if (en) begin
      if (mph[i] == pp[i] - 1) begin
        mph[i] = 0;
        e.tk = 1'b1;
        if (u) begin
          if (mc[i] == pm[i] - 1) begin
            if (ps[i] == 0) begin mc[i] = 0; e.wr = 1'b1; end
          end else mc[i]++;
        end else begin
          if (mc[i] == 0) begin
            if (ps[i] == 0) begin mc[i] = pm[i] - 1; e.wr = 1'b1; end
          end else mc[i]--;
        end
      end else begin
        mph[i]++;
      end
    end
    e.cnt = mc[i];
    sb.push_back(e);
  endtask

  task automatic cyc(input bit en, input bit u, input bit c, input bit l, input int lvv);
    exp_t e;
    @(negedge clock);
    enable = en; up = u; clear = c; load = l; lv = 4'(lvv);
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("terminal[%0d]", i), act_term(i), model_term(i, u));
    for (int i = 0; i < 4; i++) model_step(i, en, u, c, l, lvv);
    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk($sformatf("count[%0d]", e.inst),   act_cnt(e.inst), e.cnt);
      chk($sformatf("tick[%0d]", e.inst),    act_tk(e.inst),  int'(e.tk));
      chk($sformatf("wrapped[%0d]", e.inst), act_wr(e.inst),  int'(e.wr));
    end
  endtask

  // Reset lands between edges and must take effect before the next rising edge.
  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("async_rst_count[%0d]", i), act_cnt(i), 0);
      chk($sformatf("async_rst_tick[%0d]", i),  act_tk(i),  0);
      chk($sformatf("async_rst_wrap[%0d]", i),  act_wr(i),  0);
      mc[i] = 0;
      mph[i] = 0;
    end
    @(negedge clock);
    enable = 1'b0; clear = 1'b0; load = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; up = 1'b0; clear = 1'b0; load = 1'b0; lv = '0;
    for (int i = 0; i < 4; i++) begin mc[i] = 0; mph[i] = 0; end

    #12;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_count[%0d]", i), act_cnt(i), 0);
      chk($sformatf("reset_tick[%0d]", i),  act_tk(i),  0);
      chk($sformatf("reset_wrap[%0d]", i),  act_wr(i),  0);
      chk($sformatf("reset_term[%0d]", i),  act_term(i), 1);
    end
    @(negedge clock);
    reset = 1'b0;

    // en, up, clear, load, loadValue, expected A count/tick/wrapped
    tbl[0]  = '{1, 1, 0, 0, 0,  1, 1, 0};
    tbl[1]  = '{1, 1, 0, 0, 0,  2, 1, 0};
    tbl[2]  = '{1, 1, 0, 0, 0,  3, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 0,  0, 1, 1};
    tbl[4]  = '{1, 1, 0, 0, 0,  1, 1, 0};
    tbl[5]  = '{1, 1, 0, 0, 0,  2, 1, 0};
    tbl[6]  = '{0, 1, 0, 0, 0,  2, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 13, 1, 0, 0};
    tbl[8]  = '{1, 1, 1, 1, 5,  0, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0,  3, 1, 1};
    tbl[10] = '{1, 0, 0, 0, 0,  2, 1, 0};
    tbl[11] = '{0, 0, 0, 1, 3,  3, 0, 0};
    tbl[12] = '{1, 1, 0, 0, 0,  0, 1, 1};
    for (int k = 0; k < 13; k++) begin
      cyc(tbl[k].en, tbl[k].u, tbl[k].c, tbl[k].l, tbl[k].lv);
      chk($sformatf("tbl%0d_countA", k), int'(cA), tbl[k].ec);
      chk($sformatf("tbl%0d_tickA", k),  int'(tA), int'(tbl[k].et));
      chk($sformatf("tbl%0d_wrapA", k),  int'(wA), int'(tbl[k].ew));
    end

    // Count down from zero: decade wraps to 9, saturating decade holds with a tick.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    chk("down_wrap_countB", int'(cB), 9);
    chk("down_wrap_flagB",  int'(wB), 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("sat_hold_countC", int'(cC), 0);
    chk("sat_hold_tickC",  int'(tC), 1);
    chk("sat_hold_wrapC",  int'(wC), 0);
    chk("sat_hold_termC",  int'(mC), 1);

    // Load clamps above range; then reset mid-prescale restarts the phase.
    cyc(0, 1, 0, 1, 13);
    chk("load_clamp_countB", int'(cB), 9);
    cyc(0, 1, 0, 1, 5);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    do_reset();
    chk("mid_prescale_countC", int'(cC), 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("prescale3_countC", int'(cC), 0);
    cyc(1, 1, 0, 0, 0);
    chk("prescale4_countC", int'(cC), 1);
    chk("prescale4_tickC",  int'(tC), 1);

    // Octal counter at its top wraps cleanly to zero.
    cyc(0, 1, 0, 1, 7);
    chk("top_termD", int'(mD), 1);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("top_wrap_countD", int'(cD), 0);
    chk("top_wrap_flagD",  int'(wD), 1);
    #1;
    chk("zero_termD", int'(mD), 0);

    // Gapped enables against the prescale-3 counter.
    do_reset();
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);

    for (int n = 0; n < 300; n++)
      cyc(($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 25) == 0,
          ($urandom % 15) == 0, int'($urandom % 16));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
